free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular FIFO of free physical-register indices for the renamer.
//  - Tail side: written by the retirement register file, which enqueues the
//    previous mapping of each committed rd.
//  - Head side: read by rename/dispatch, which pops one preg per renamed rd.
//  - On a branch mispredict the list is restored to full by pointer
//    manipulation only, with no data movement.
// PARAMETERS
//  PHYS_REG_IDX  (default rv32i_types::PHYS_REG_IDX)  MSB of a preg index; index width = PHYS_REG_IDX+1
//  NUM_PHYS_REG  (default 64)  total physical registers
//  NUM_ARCH_REG  (default rv32i_types::NUM_ARCH_REG = 32)  architectural registers
//  DEPTH         (derived: NUM_PHYS_REG-NUM_ARCH_REG)  entries; must be a power of 2
// PORTS
//  clk        in   1     clock, rising edge; the only clock
//  rst_n      in   1     reset, asynchronous, active-low
//  enqueue    in   1     RRF frees a preg this cycle
//  enq_preg   in   PHYS_REG_IDX+1  preg being freed
//  dequeue    in   1     rename consumes head entry this cycle
//  deq_preg   out  PHYS_REG_IDX+1  head entry (combinational from storage)
//  deq_valid  out  1     head entry valid (= !empty)
//  full       out  1     all DEPTH entries free
//  flush      in   1     branch mispredict at commit; restore list to full
//  count      out  $clog2(DEPTH)+1  number of free entries
//  err_dup    out  1     sticky: preg enqueued while already free
// BEHAVIOUR
//  Storage, pointers and reset
//  - Storage mem[DEPTH]. Pointers rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits
//    wide; the extra MSB is the wrap bit.
//  - empty when rd_ptr==wr_ptr. full when the pointers differ only in the MSB.
//  - Reset (async, rst_n=0): mem[i]=NUM_ARCH_REG+i; rd_ptr=0; wr_ptr={1,0..0}.
//    Outputs at reset: full=1, deq_valid=1, deq_preg=NUM_ARCH_REG,
//    count=DEPTH, err_dup=0.
//  Dequeue
//  - Zero latency: deq_preg is valid in the same cycle as deq_valid.
//  - dequeue&&deq_valid: rd_ptr++ at the clock edge.
//  - dequeue while empty: ignored; no pointer move.
//  Enqueue
//  - enqueue&&!full: mem[wr_ptr]<=enq_preg and wr_ptr++. The new entry is
//    visible on deq_preg the next cycle; there is no same-cycle bypass.
//  - enqueue while full: dropped, state unchanged. A simulation assertion fires.
//  Simultaneous enqueue and dequeue
//  - Both take effect; count is unchanged.
//  - When empty: only the enqueue occurs. When full: both occur.
//  Flush
//  - flush=1: dequeue is ignored that cycle.
//  - Any enqueue in the same cycle is applied first; call the resulting write
//    pointer wr_nxt.
//  - Then rd_ptr<={~wr_nxt[MSB],wr_nxt[MSB-1:0]}, so the list becomes full.
//  - Valid because after a commit-time flush exactly DEPTH pregs are
//    unmapped: one is the slot already enqueued, the rest are entries still
//    held in storage.
//  - Next cycle: full=1, count=DEPTH.
//  Count and wrap
//  - count=wr_ptr-rd_ptr, computed modulo 2^(ptr width); registered next to
//    the pointers.
//  - Pointer increments wrap naturally; no compare against DEPTH is needed.
//  Reset mid-operation
//  - Asserting rst_n aborts all traffic and reloads the reset image
//    immediately (asynchronously).
// CONFIGURATION
//  FREE_LIST_DUP_CHECK_EN defined
//  - Keeps a NUM_PHYS_REG-bit is_free vector.
//  - Bits are set on accepted enqueue, cleared on accepted dequeue, and set
//    for every queued entry on flush.
//  - Enqueue of a preg whose bit is already 1 sets err_dup (sticky until
//    reset) and fires $error.
//  - Reset: bits NUM_ARCH_REG..NUM_PHYS_REG-1 set.
//  FREE_LIST_DUP_CHECK_EN undefined
//  - No vector is built; err_dup is tied to 0.
// STRUCTURE
//  rv32i_types package
//  - Add NUM_PHYS_REG and typedef logic [PHYS_REG_IDX:0] preg_idx_t.
//  - Use preg_idx_t for enq_preg and deq_preg.
//  - Add free_list_ptr_t sized from DEPTH.
//  Sub-module
//  - free_list_dup_check holds the is_free vector and err_dup logic and is
//    instantiated only under the macro.
//  - Pointer and storage logic stay in free_list.
// TESTING
//  T1 reset: release rst_n -> deq_preg=32, count=32, full=1, deq_valid=1.
//  T2 drain: 32 back-to-back dequeues -> deq_preg 32..63 in order; then
//     deq_valid=0 and count=0; a further dequeue leaves state unchanged.
//  T3 refill+wrap: from empty, enqueue 40,7,63; next cycle dequeue x3 ->
//     7? no: returns 40,7,63 FIFO; then 40 more enq/deq pairs -> pointers wrap,
//     order preserved, count steady.
//  T4 flush: drain 10 (count=22), enqueue 3 (count=25), pulse flush ->
//     next cycle full=1, count=32, deq_preg = the entry after the last
//     enqueued slot.
//  T5 flush+enqueue same cycle: count=20, enqueue preg 5 with flush=1 ->
//     count=32, and preg 5 is present 31 pops later.
//  T6 dup (macro on): at reset, enqueue preg 40 (full, so dropped with the
//     assertion), then dequeue one and enqueue 45 -> err_dup=1 and sticky.
//     Macro off -> err_dup stays 0.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared types for the renamer's physical-register free list.
// rv32i_types holds the register-file geometry. free_list_pkg holds the
// pointer helpers used by free_list.
// Optional feature macro: FREE_LIST_DUP_CHECK_EN (see rtl/free_list.sv).
package rv32i_types;
  localparam int PHYS_REG_IDX = 5;
  localparam int NUM_ARCH_REG = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int FREE_LIST_DEPTH = NUM_PHYS_REG - NUM_ARCH_REG;

  typedef logic [PHYS_REG_IDX:0] preg_idx_t;
  // One extra MSB beyond the index bits acts as the wrap bit.
  typedef logic [$clog2(FREE_LIST_DEPTH):0] free_list_ptr_t;
endpackage

package free_list_pkg;
  // Pointer width for a circular buffer of `depth` entries, including the wrap bit.
  function automatic int fl_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // The depth must be a power of two so that pointer increments can wrap
  // without a compare.
  function automatic bit fl_is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/free_list_if.sv
// Handshake bundle between the free list and its users. The RRF (tail) and
// rename/dispatch (head) drive it through the master modport. The free list
// uses the slave modport.
// Optional feature macro: FREE_LIST_DUP_CHECK_EN (err_dup is only live with it).
interface free_list_if;
  logic                       enqueue;
  rv32i_types::preg_idx_t      enq_preg;
  logic                       dequeue;
  rv32i_types::preg_idx_t      deq_preg;
  logic                       deq_valid;
  logic                       full;
  logic                       flush;
  rv32i_types::free_list_ptr_t count;
  logic                       err_dup;

  modport master (
    output enqueue, enq_preg, dequeue, flush,
    input  deq_preg, deq_valid, full, count, err_dup
  );

  modport slave (
    input  enqueue, enq_preg, dequeue, flush,
    output deq_preg, deq_valid, full, count, err_dup
  );
endinterface

// File: rtl/free_list_dup_check.sv
// Double-free detector for the free list. It tracks one "is free" bit per
// physical register and raises a sticky err_dup when a preg that is already
// free gets enqueued. It is instantiated only when FREE_LIST_DUP_CHECK_EN is defined.
module free_list_dup_check #(
  parameter int PHYS_REG_IDX = 5,
  parameter int NUM_PHYS_REG = 64,
  parameter int NUM_ARCH_REG = 32,
  parameter int DEPTH        = 32,
  parameter int AW           = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enq_ok,
  input  logic [PHYS_REG_IDX:0]   enq_preg,
  input  logic                    deq_ok,
  input  logic [PHYS_REG_IDX:0]   deq_preg,
  input  logic                    flush,
  input  logic [PHYS_REG_IDX:0]   mem [DEPTH],
  input  logic [AW-1:0]           wr_idx,
  output logic                    err_dup
);
  localparam logic [NUM_PHYS_REG-1:0] FREE_RST = {NUM_PHYS_REG{1'b1}} << NUM_ARCH_REG;

  logic [NUM_PHYS_REG-1:0] is_free;
  logic [NUM_PHYS_REG-1:0] is_free_nxt;
  logic                    dup_hit;

  assign dup_hit = enq_ok && is_free[enq_preg];

  // Next free vector. On flush every slot of storage is back in the list.
  // The slot written this cycle holds enq_preg instead of its stale contents.
  always_comb begin
    is_free_nxt = is_free;
    if (deq_ok) is_free_nxt[deq_preg] = 1'b0;
    if (enq_ok) is_free_nxt[enq_preg] = 1'b1;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(enq_ok && (int'(wr_idx) == i))) is_free_nxt[mem[i]] = 1'b1;
      end
    end
  end

  // Free vector and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_free <= FREE_RST;
      err_dup <= 1'b0;
    end else begin
      is_free <= is_free_nxt;
      if (dup_hit) err_dup <= 1'b1;
    end
  end

  dup_free_chk: assert property (@(posedge clk) disable iff (!rst_n) !dup_hit)
    else $error("free_list: preg %0d enqueued while already free", enq_preg);
endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical-register indices for the renamer.
// The tail is fed by the retirement register file. The head is popped by rename.
// A commit-time flush makes the list full again by moving rd_ptr only; no data moves.
// Optional feature: define FREE_LIST_DUP_CHECK_EN to build the double-free
// detector (free_list_dup_check). Without it, err_dup is tied to 0.
module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REG_IDX = rv32i_types::PHYS_REG_IDX,
  parameter int NUM_PHYS_REG = 64,
  parameter int NUM_ARCH_REG = rv32i_types::NUM_ARCH_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  free_list_if.slave  fl
);
  localparam int DEPTH = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = fl_ptr_w(DEPTH);

  typedef logic [PHYS_REG_IDX:0] preg_t;
  typedef logic [PW-1:0]         ptr_t;

  // Flipping the wrap bit gives the pointer exactly DEPTH entries away.
  function automatic ptr_t flip_wrap(input ptr_t p);
    return {~p[PW-1], p[PW-2:0]};
  endfunction

  preg_t         mem [DEPTH];
  ptr_t          rd_ptr, wr_ptr, count_q;
  ptr_t          rd_nxt, wr_nxt;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          empty, full, enq_ok, deq_ok;

  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];
  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_ptr == flip_wrap(wr_ptr));

  // A flush overrides rename's pop. An enqueue into a full list is accepted only
  // when the head leaves in the same cycle. The slot being written is then the
  // one being popped.
  assign deq_ok = fl.dequeue && !empty && !fl.flush;
  assign enq_ok = fl.enqueue && (!full || deq_ok);

  // Pointer update. A flush applies the same-cycle enqueue first, then places
  // rd_ptr a full DEPTH behind it.
  always_comb begin
    wr_nxt = wr_ptr + ptr_t'(enq_ok);
    rd_nxt = rd_ptr + ptr_t'(deq_ok);
    if (fl.flush) rd_nxt = flip_wrap(wr_nxt);
  end

  // Storage. The reset image is pregs NUM_ARCH_REG.. in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= preg_t'(NUM_ARCH_REG + i);
    end else if (enq_ok) begin
      mem[wr_idx] <= fl.enq_preg;
    end
  end

  // Pointers and the registered occupancy count. The list starts out full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= ptr_t'(DEPTH);
      count_q <= ptr_t'(DEPTH);
    end else begin
      rd_ptr  <= rd_nxt;
      wr_ptr  <= wr_nxt;
      count_q <= wr_nxt - rd_nxt;
    end
  end

  assign fl.deq_preg  = mem[rd_idx];
  assign fl.deq_valid = !empty;
  assign fl.full      = full;
  assign fl.count     = count_q;

`ifdef FREE_LIST_DUP_CHECK_EN
  free_list_dup_check #(
    .PHYS_REG_IDX (PHYS_REG_IDX),
    .NUM_PHYS_REG (NUM_PHYS_REG),
    .NUM_ARCH_REG (NUM_ARCH_REG),
    .DEPTH        (DEPTH),
    .AW           (AW)
  ) u_dup_check (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_ok   (enq_ok),
    .enq_preg (fl.enq_preg),
    .deq_ok   (deq_ok),
    .deq_preg (fl.deq_preg),
    .flush    (fl.flush),
    .mem      (mem),
    .wr_idx   (wr_idx),
    .err_dup  (fl.err_dup)
  );
`else
  assign fl.err_dup = 1'b0;
`endif

  // More frees than physical registers means the RRF and rename have
  // diverged. The dropped preg is reported rather than overwriting a live slot.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(fl.enqueue && full && !deq_ok))
    else $warning("free_list: enqueue of preg %0d while full dropped", fl.enq_preg);
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list. It uses a hand-written vector table,
// directed corner sequences and randomized traffic. All three are compared
// against a queue-based reference model.
// Honors FREE_LIST_DUP_CHECK_EN to decide the expected err_dup behaviour.
module tb_free_list;
  localparam int DEPTH = 32;
`ifdef FREE_LIST_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  free_list_if fl_bus ();

  free_list #(
    .PHYS_REG_IDX (5),
    .NUM_PHYS_REG (64),
    .NUM_ARCH_REG (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model. q is the free list in pop order. hist holds the last
  // DEPTH pregs ever written to storage, which is exactly what a flush restores.
  int q[$];
  int hist[$];
  bit free_bits[64];
  bit m_err;

  typedef struct {
    bit enq; int preg; bit deq; bit flush;
    int e_count; bit e_full; int e_preg;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hist.delete();
    for (int i = 0; i < 64; i++) free_bits[i] = (i >= 32);
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(32 + i);
      hist.push_back(32 + i);
    end
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit enq, input int preg, input bit deq, input bit flush);
    bit deq_ok;
    bit enq_ok;
    deq_ok = deq && (q.size() != 0) && !flush;
    enq_ok = enq && ((q.size() != DEPTH) || deq_ok);
    if (enq_ok && free_bits[preg]) m_err = 1'b1;
    if (deq_ok) begin
      free_bits[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (enq_ok) begin
      free_bits[preg] = 1'b1;
      q.push_back(preg);
      hist.push_back(preg);
      if (hist.size() > DEPTH) void'(hist.pop_front());
    end
    if (flush) begin
      q = hist;
      foreach (hist[i]) free_bits[hist[i]] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(fl_bus.count), q.size());
    chk({tag, ".valid"}, 32'(fl_bus.deq_valid), int'(q.size() != 0));
    chk({tag, ".full"}, 32'(fl_bus.full), int'(q.size() == DEPTH));
    if (q.size() != 0) chk({tag, ".deq_preg"}, 32'(fl_bus.deq_preg), q[0]);
    chk({tag, ".err_dup"}, 32'(fl_bus.err_dup), DUP_EN ? int'(m_err) : 0);
  endtask

  task automatic step(input bit enq, input int preg, input bit deq, input bit flush,
                      input string tag);
    int p;
    p = preg;
    @(negedge clk);
    fl_bus.enqueue  = enq;
    fl_bus.enq_preg = p[5:0];
    fl_bus.dequeue  = deq;
    fl_bus.flush    = flush;
    @(posedge clk);
    #1;
    fl_bus.enqueue = 1'b0;
    fl_bus.dequeue = 1'b0;
    fl_bus.flush   = 1'b0;
    model_step(enq, preg, deq, flush);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    fl_bus.enqueue  = 1'b0;
    fl_bus.enq_preg = '0;
    fl_bus.dequeue  = 1'b0;
    fl_bus.flush    = 1'b0;

    tbl[0] = '{0, 0,  0, 0, 32, 1, 32};
    tbl[1] = '{0, 0,  1, 0, 31, 0, 33};
    tbl[2] = '{1, 5,  1, 0, 31, 0, 34};
    tbl[3] = '{1, 9,  0, 0, 32, 1, 34};
    tbl[4] = '{1, 7,  0, 0, 32, 1, 34};
    tbl[5] = '{1, 11, 1, 0, 32, 1, 35};
    tbl[6] = '{0, 0,  1, 0, 31, 0, 36};
    tbl[7] = '{0, 0,  1, 0, 30, 0, 37};
    tbl[8] = '{0, 0,  1, 1, 32, 1, 35};

    // T1: reset image
    do_reset();
    chk("t1.deq_preg", 32'(fl_bus.deq_preg), 32);
    chk("t1.count", 32'(fl_bus.count), 32);
    chk("t1.full", 32'(fl_bus.full), 1);
    chk("t1.valid", 32'(fl_bus.deq_valid), 1);

    // Vector table: pop, pop+push, push to full, dropped push, push+pop when full, flush
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].enq, tbl[i].preg, tbl[i].deq, tbl[i].flush, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.count_v", i), 32'(fl_bus.count), tbl[i].e_count);
      chk($sformatf("tbl%0d.full_v", i), 32'(fl_bus.full), int'(tbl[i].e_full));
      chk($sformatf("tbl%0d.preg_v", i), 32'(fl_bus.deq_preg), tbl[i].e_preg);
    end

    // T2: drain
    do_reset();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t2.head%0d", i), 32'(fl_bus.deq_preg), 32 + i);
      step(0, 0, 1, 0, "t2");
    end
    chk("t2.empty_valid", 32'(fl_bus.deq_valid), 0);
    chk("t2.empty_count", 32'(fl_bus.count), 0);
    step(0, 0, 1, 0, "t2.underflow");
    chk("t2.underflow_count", 32'(fl_bus.count), 0);

    // T3: refill from empty, then steady enq/deq traffic across the wrap
    step(1, 40, 0, 0, "t3");
    step(1, 7, 0, 0, "t3");
    step(1, 63, 0, 0, "t3");
    chk("t3.head0", 32'(fl_bus.deq_preg), 40);
    step(0, 0, 1, 0, "t3");
    chk("t3.head1", 32'(fl_bus.deq_preg), 7);
    step(0, 0, 1, 0, "t3");
    chk("t3.head2", 32'(fl_bus.deq_preg), 63);
    step(0, 0, 1, 0, "t3");
    step(1, 10, 0, 0, "t3.seed");
    for (int k = 0; k < 40; k++) step(1, (k * 7 + 1) % 64, 1, 0, "t3.pair");
    chk("t3.steady_count", 32'(fl_bus.count), 1);

    // T4: drain 10, enqueue 3, flush
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, "t4.drain");
    chk("t4.count22", 32'(fl_bus.count), 22);
    for (int i = 1; i <= 3; i++) step(1, i, 0, 0, "t4.enq");
    chk("t4.count25", 32'(fl_bus.count), 25);
    step(0, 0, 0, 1, "t4.flush");
    chk("t4.count32", 32'(fl_bus.count), 32);
    chk("t4.full", 32'(fl_bus.full), 1);
    chk("t4.head", 32'(fl_bus.deq_preg), 35);

    // T5: flush and enqueue in the same cycle
    do_reset();
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, "t5.drain");
    chk("t5.count20", 32'(fl_bus.count), 20);
    step(1, 5, 1, 1, "t5.flush_enq");
    chk("t5.count32", 32'(fl_bus.count), 32);
    chk("t5.head", 32'(fl_bus.deq_preg), 33);
    for (int i = 0; i < 31; i++) step(0, 0, 1, 0, "t5.pop");
    chk("t5.preg5", 32'(fl_bus.deq_preg), 5);

    // T6: duplicate free
    do_reset();
    step(1, 40, 0, 0, "t6.drop");
    step(0, 0, 1, 0, "t6.deq");
    step(1, 45, 0, 0, "t6.dup");
    chk("t6.err_dup", 32'(fl_bus.err_dup), int'(DUP_EN));
    step(0, 0, 0, 0, "t6.idle");
    step(0, 0, 1, 0, "t6.idle");
    chk("t6.err_sticky", 32'(fl_bus.err_dup), int'(DUP_EN));

    // Reset asserted mid-cycle acts without waiting for a clock edge
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, "arst.pre");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.count", 32'(fl_bus.count), 32);
    chk("arst.head", 32'(fl_bus.deq_preg), 32);
    chk("arst.full", 32'(fl_bus.full), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(99) < 45, int'($urandom_range(63)), $urandom_range(99) < 50,
           $urandom_range(99) < 3, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
